// File: rtl/axi_stream_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI-Stream round-robin arbiter.
// Holds the FSM state encoding, the grant index width helper and the
// round-robin pick function used by axi_stream_rr_arbiter.
package axi_stream_arb_pkg;

    // Arbiter FSM: waiting for a request, or holding a grant until TLAST.
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Largest supported source count; the pick function works on vectors this wide.
    localparam int RR_MAX_SRC = 16;

    // Width of a source index; a single source still needs one bit.
    function automatic int idx_w(input int n);
        int w;
        if (n <= 1) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

    // First requester searching upward from last+1, wrapping modulo n.
    function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  last,
                                           input int          n);
        logic [3:0] pick;
        logic       found;
        int         cand;
        pick  = 4'd0;
        found = 1'b0;
        cand  = 0;
        for (int i = 1; i <= RR_MAX_SRC; i++) begin
            if (i <= n) begin
                cand = (int'(last) + i) % n;
                if (!found && req[cand]) begin
                    pick  = cand[3:0];
                    found = 1'b1;
                end else begin
                    found = found;
                end
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axi_stream_skid_buffer.sv
// Two-entry skid buffer for a valid/ready stream of arbitrary payload width.
// Output valid/data and input ready are all driven from flops, so there is no
// combinational path from out_ready_i back to in_ready_o. Reusable anywhere a
// register slice with full throughput is needed.
module axi_stream_skid_buffer #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [PW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [PW-1:0] out_data_o
);

    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_data_q,  out_data_d;
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] skid_data_q,  skid_data_d;

    // Next state: refill the output slot from the skid entry first, else from the input;
    // park an incoming beat in the skid entry when the output slot is stalled.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_ready_i || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_valid_i) begin
                out_valid_d  = 1'b1;
                out_data_d   = in_data_i;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else begin
            if (in_valid_i && !skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // State registers; reset empties both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= {PW{1'b0}};
            skid_valid_q <= 1'b0;
            skid_data_q  <= {PW{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: rtl/axi_stream_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXI4-Stream slaves onto
// one master. A grant is held from the first beat through the TLAST handshake.
// Optional macro AXIS_ARB_OUT_REG_EN inserts a registered skid buffer on the
// master side (+1 cycle latency); without it the pass-through is combinational.
module axi_stream_rr_arbiter
    import axi_stream_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int byte_width = 4,
    parameter int user_width = 1,
    localparam int IDXW      = idx_w(NUM_SRC)
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [NUM_SRC-1:0]              s_tvalid,
    output logic [NUM_SRC-1:0]              s_tready,
    input  logic [NUM_SRC*8*byte_width-1:0] s_tdata,
    input  logic [NUM_SRC*byte_width-1:0]   s_tkeep,
    input  logic [NUM_SRC-1:0]              s_tlast,
    input  logic [NUM_SRC*user_width-1:0]   s_tuser,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [8*byte_width-1:0]         m_tdata,
    output logic [byte_width-1:0]           m_tkeep,
    output logic                            m_tlast,
    output logic [user_width-1:0]           m_tuser,
    output logic                            grant_valid,
    output logic [IDXW-1:0]                 grant_idx
);

    localparam int DW = 8 * byte_width;
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_SRC - 1);

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] grant_q, grant_d;
    logic [IDXW-1:0] last_q,  last_d;

    logic [DW-1:0]         src_data_s [NUM_SRC];
    logic [byte_width-1:0] src_keep_s [NUM_SRC];
    logic [user_width-1:0] src_user_s [NUM_SRC];

    logic                  locked_s;
    logic                  sel_valid_s;
    logic                  sel_last_s;
    logic [DW-1:0]         sel_data_s;
    logic [byte_width-1:0] sel_keep_s;
    logic [user_width-1:0] sel_user_s;
    logic                  fwd_ready_s;
    logic                  hs_last_s;
    logic [3:0]            pick_s;

    // Unpack the per-source payload slices.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_data_s[g] = s_tdata[g*DW +: DW];
        assign src_keep_s[g] = s_tkeep[g*byte_width +: byte_width];
        assign src_user_s[g] = s_tuser[g*user_width +: user_width];
    end

    assign locked_s    = (state_q == ARB_LOCKED);
    assign sel_valid_s = s_tvalid[grant_q];
    assign sel_last_s  = s_tlast[grant_q];
    assign sel_data_s  = src_data_s[grant_q];
    assign sel_keep_s  = src_keep_s[grant_q];
    assign sel_user_s  = src_user_s[grant_q];
    assign pick_s      = rr_pick(16'(s_tvalid), 4'(last_q), NUM_SRC);

    // Packet end: TLAST beat of the granted source accepted by the forward stage.
    assign hs_last_s = locked_s & sel_valid_s & fwd_ready_s & sel_last_s;

    // Ready fan-out: only the granted source sees the forward-stage ready.
    always_comb begin
        s_tready = {NUM_SRC{1'b0}};
        if (locked_s) begin
            s_tready[grant_q] = fwd_ready_s;
        end else begin
            s_tready = {NUM_SRC{1'b0}};
        end
    end

`ifdef AXIS_ARB_OUT_REG_EN
    localparam int PW = DW + byte_width + 1 + user_width;

    logic [PW-1:0] skid_out_s;

    axi_stream_skid_buffer #(
        .PW (PW)
    ) u_skid (
        .clk         (aclk),
        .rst         (areset),
        .in_valid_i  (locked_s & sel_valid_s),
        .in_ready_o  (fwd_ready_s),
        .in_data_i   ({sel_user_s, sel_last_s, sel_keep_s, sel_data_s}),
        .out_valid_o (m_tvalid),
        .out_ready_i (m_tready),
        .out_data_o  (skid_out_s)
    );

    assign {m_tuser, m_tlast, m_tkeep, m_tdata} = skid_out_s;
`else
    assign fwd_ready_s = m_tready;
    assign m_tvalid    = locked_s & sel_valid_s;
    assign m_tdata     = sel_data_s;
    assign m_tkeep     = sel_keep_s;
    assign m_tlast     = sel_last_s;
    assign m_tuser     = sel_user_s;
`endif

    // FSM next state: grant on any request in IDLE, release after the TLAST handshake.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (|s_tvalid) begin
                    state_d = ARB_LOCKED;
                    grant_d = pick_s[IDXW-1:0];
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (hs_last_s) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                end else begin
                    state_d = ARB_LOCKED;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // FSM registers; reset wins over a same-edge TLAST handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ARB_IDLE;
            grant_q <= {IDXW{1'b0}};
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign grant_valid = locked_s;
    assign grant_idx   = grant_q;

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Scoreboard bench for axi_stream_rr_arbiter (NUM_SRC=4, 4-byte data, 1-bit user).
// Expected master beats are queued in grant order when stimulus is issued; a
// negedge monitor pops and compares on every master handshake.
module tb_axi_stream_rr_arbiter;

    localparam int NS = 4;
    localparam int BW = 4;
    localparam int UW = 1;

    typedef struct {
        logic [3:0]  src;
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        int          gap;
    } beat_t;

    logic            aclk;
    logic            areset;
    logic [NS-1:0]   s_tvalid;
    logic [NS-1:0]   s_tready;
    logic [NS*32-1:0] s_tdata;
    logic [NS*BW-1:0] s_tkeep;
    logic [NS-1:0]   s_tlast;
    logic [NS*UW-1:0] s_tuser;
    logic            m_tvalid;
    logic            m_tready;
    logic [31:0]     m_tdata;
    logic [BW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [UW-1:0]   m_tuser;
    logic            grant_valid;
    logic [1:0]      grant_idx;

    beat_t src_q [NS][$];
    beat_t exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    axi_stream_rr_arbiter #(
        .NUM_SRC    (NS),
        .byte_width (BW),
        .user_width (UW)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tlast     (m_tlast),
        .m_tuser     (m_tuser),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input logic ok, input string name,
                         input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (ok === 1'b1) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic beat_t mk_beat(input int src, input int pkt, input int b,
                                      input int n, input int gap);
        beat_t e;
        e.src  = 4'(src);
        e.data = {4'(src), 4'hA, 8'(pkt), 16'(b)};
        e.keep = (b == n - 1) ? 4'h3 : 4'hF;
        e.last = (b == n - 1);
        e.user = b[0];
        e.gap  = gap;
        return e;
    endfunction

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                s_tvalid[i]          = 1'b1;
                s_tdata[i*32 +: 32]  = src_q[i][0].data;
                s_tkeep[i*BW +: BW]  = src_q[i][0].keep;
                s_tlast[i]           = src_q[i][0].last;
                s_tuser[i]           = src_q[i][0].user;
            end else begin
                s_tvalid[i]          = 1'b0;
            end
        end
    endtask

    // Source side: offer a packet on one slave port.
    task automatic add_pkt(input int src, input int pkt, input int n);
        for (int b = 0; b < n; b++) src_q[src].push_back(mk_beat(src, pkt, b, n, 0));
        drive();
    endtask

    // Expected master-side beats, pushed in predicted grant order.
    task automatic expect_pkt(input int src, input int pkt, input int n,
                              input int gap0, input int gap_inner);
        for (int b = 0; b < n; b++)
            exp_q.push_back(mk_beat(src, pkt, b, n, (b == 0) ? gap0 : gap_inner));
    endtask

    // One clock: note slave handshakes before the edge, retire them after it.
    task automatic step();
        logic [NS-1:0] hs;
        @(negedge aclk);
        hs = s_tvalid & s_tready;
        @(posedge aclk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive();
    endtask

    function automatic logic all_empty();
        logic e;
        e = (exp_q.size() == 0);
        for (int i = 0; i < NS; i++) e = e && (src_q[i].size() == 0);
        return e;
    endfunction

    task automatic wait_empty(input string name);
        for (int k = 0; k < 400 && !all_empty(); k++) step();
        check(all_empty(), name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: scoreboard compare, inter-beat gap and stall stability.
    int          cyc = 0;
    int          last_cyc = 0;
    logic        hold = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last;
    beat_t       e;

    always @(negedge aclk) begin
        cyc++;
        if (areset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check(m_tvalid && m_tdata == hold_data && m_tlast == hold_last,
                      "stall_stable", m_tdata, hold_data);
            end
            if (m_tvalid && m_tready) begin
                check(exp_q.size() > 0, "beat_expected", m_tdata, 32'd0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check(m_tdata == e.data && m_tkeep == e.keep && m_tlast == e.last &&
                          m_tuser == e.user, "beat", m_tdata, e.data);
                    if (e.gap != 0) check(cyc - last_cyc == e.gap, "beat_gap",
                                          32'(cyc - last_cyc), 32'(e.gap));
`ifndef AXIS_ARB_OUT_REG_EN
                    check(grant_valid && grant_idx == e.src[1:0], "beat_grant",
                          32'(grant_idx), 32'(e.src));
`endif
                    last_cyc = cyc;
                end
            end
            hold      = m_tvalid && !m_tready;
            hold_data = m_tdata;
            hold_last = m_tlast;
        end
    end

    initial begin
        areset   = 1'b1;
        m_tready = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        step();
        step();
        check(m_tvalid == 1'b0, "rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check(grant_valid == 1'b0, "rst_grant_valid", 32'(grant_valid), 32'd0);
        check(s_tready == 4'b0000, "rst_s_tready", 32'(s_tready), 32'd0);
        check(grant_idx == 2'd0, "rst_grant_idx", 32'(grant_idx), 32'd0);
        areset = 1'b0;
        step();

        // Round robin: sources 0,1,3 each with two 2-beat packets.
        add_pkt(0, 1, 2); add_pkt(0, 2, 2);
        add_pkt(1, 3, 2); add_pkt(1, 4, 2);
        add_pkt(3, 5, 2); add_pkt(3, 6, 2);
        expect_pkt(0, 1, 2, 0, 1);
        expect_pkt(1, 3, 2, 2, 1);
        expect_pkt(3, 5, 2, 2, 1);
        expect_pkt(0, 2, 2, 2, 1);
        expect_pkt(1, 4, 2, 2, 1);
        expect_pkt(3, 6, 2, 2, 1);
        wait_empty("rr_drain");
        step(); step();

        // Single 3-beat packet on source 2.
        add_pkt(2, 20, 3);
        expect_pkt(2, 20, 3, 0, 1);
        check(grant_valid == 1'b0, "t1_pre_grant", 32'(grant_valid), 32'd0);
        step();
        check(grant_valid == 1'b1, "t1_grant_valid", 32'(grant_valid), 32'd1);
        check(grant_idx == 2'd2, "t1_grant_idx", 32'(grant_idx), 32'd2);
        check(s_tready == 4'b0100, "t1_s_tready", 32'(s_tready), 32'h4);
`ifdef AXIS_ARB_OUT_REG_EN
        check(m_tvalid == 1'b0, "t1_latency", 32'(m_tvalid), 32'd0);
        step();
        check(m_tvalid == 1'b1, "t1_first_beat", 32'(m_tvalid), 32'd1);
`else
        check(m_tvalid == 1'b1, "t1_first_beat", 32'(m_tvalid), 32'd1);
`endif
        wait_empty("t1_drain");
        check(grant_valid == 1'b0, "t1_release", 32'(grant_valid), 32'd0);
        step(); step();

        // Backpressure: 5 stalled cycles in the middle of a 4-beat packet.
        add_pkt(2, 30, 4);
        expect_pkt(2, 30, 4, 0, 0);
        for (int k = 0; k < 50 && src_q[2].size() > 2; k++) step();
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k >= 2) check(s_tready[2] == 1'b0, "bp_s_tready", 32'(s_tready), 32'd0);
        end
        m_tready = 1'b1;
        wait_empty("bp_drain");
        step(); step();

        // Late arrival: source 0 requests while source 1 is locked.
        add_pkt(1, 40, 4);
        expect_pkt(1, 40, 4, 0, 1);
        step(); step();
        add_pkt(0, 41, 2);
        expect_pkt(0, 41, 2, 2, 1);
        wait_empty("late_drain");
        step(); step();

        // Reset during a 4-beat packet on source 3, after two beats delivered.
        add_pkt(3, 50, 4);
        expect_pkt(3, 50, 4, 0, 1);
        for (int k = 0; k < 50 && exp_q.size() > 2; k++) step();
        check(exp_q.size() == 2, "rst_mid_reached", 32'(exp_q.size()), 32'd2);
        areset   = 1'b1;
        m_tready = 1'b0;
        src_q[3].delete();
        exp_q.delete();
        drive();
        step();
        check(m_tvalid == 1'b0, "rst_mid_m_tvalid", 32'(m_tvalid), 32'd0);
        check(grant_valid == 1'b0, "rst_mid_grant", 32'(grant_valid), 32'd0);
        check(s_tready == 4'b0000, "rst_mid_s_tready", 32'(s_tready), 32'd0);
        areset   = 1'b0;
        m_tready = 1'b1;
        add_pkt(2, 60, 2);
        add_pkt(0, 61, 2);
        expect_pkt(0, 61, 2, 0, 1);
        expect_pkt(2, 60, 2, 2, 1);
        wait_empty("post_rst_drain");
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_stream_rr_arbiter.md
# axi_stream_rr_arbiter

Packet-granular round-robin arbiter that merges `NUM_SRC` AXI4-Stream slave ports onto one AXI4-Stream master port. A grant is held from the first beat of a packet through its TLAST handshake, so packets are never interleaved. It sits upstream of any single-consumer stream sink, such as a DMA write engine or a serializer. Its master port must satisfy the team's AXI-Stream master property set.

## Interface

Parameters:
- `NUM_SRC`, 4: number of slave ports (1..16).
- `byte_width`, 4: TDATA width in bytes (≥1).
- `user_width`, 1: TUSER width (≥1).

Ports:
- `aclk` in 1: single clock; all logic on rising edge.
- `areset` in 1: synchronous, active-high reset.
- `s_tvalid` in NUM_SRC: per-source TVALID.
- `s_tready` out NUM_SRC: per-source TREADY.
- `s_tdata` in NUM_SRC*8*byte_width: packed, source i at slice i.
- `s_tkeep` in NUM_SRC*byte_width: packed TKEEP.
- `s_tlast` in NUM_SRC: per-source TLAST.
- `s_tuser` in NUM_SRC*user_width: packed TUSER.
- `m_tvalid` out 1, `m_tready` in 1.
- `m_tdata` out 8*byte_width, `m_tkeep` out byte_width, `m_tlast` out 1, `m_tuser` out user_width.
- `grant_valid` out 1: high while a source is granted.
- `grant_idx` out IDXW = max(1, clog2(NUM_SRC)): granted source index.

## Operation

- Two-state FSM: `IDLE` and `LOCKED`.
- **IDLE**
  - All `s_tready` are 0 and `m_tvalid` is 0.
  - If any `s_tvalid` is high, pick the first requester searching from `last_grant+1` upward, wrapping modulo NUM_SRC.
  - Register the pick into `grant_idx` and go to `LOCKED`.
- **LOCKED**
  - Slave-to-master pass-through: `m_tvalid = s_tvalid[grant_idx]`, and `m_tdata/tkeep/tlast/tuser` come from slice `grant_idx`.
  - Master-to-slave: `s_tready[grant_idx] = m_tready`; every other `s_tready` is 0.
  - On `m_tvalid && m_tready && m_tlast`: set `last_grant <= grant_idx` and go to `IDLE`.
- The grant never changes inside `LOCKED`. Master-port data stability therefore follows directly from source compliance; the arbiter never switches data under a pending `m_tvalid`.
- If a source drops TVALID mid-packet, `m_tvalid` follows it and the grant is held.
- Requests that arrive while `LOCKED` wait and do not affect the current grant.
- `NUM_SRC=1`: arbitration is trivial and the FSM still inserts the IDLE cycle.
- Fairness: a continuously requesting source waits at most NUM_SRC-1 packets.

## Timing

Reset values:
- State = `IDLE`.
- `last_grant` = NUM_SRC-1, so source 0 wins first.
- `grant_idx` = 0, `grant_valid` = 0, `m_tvalid` = 0, all `s_tready` = 0.
- Data outputs are don't-care while `m_tvalid` = 0.

Cycle-level behaviour:
- Arbitration latency: a request seen in `IDLE` at edge N is granted at N+1; the first beat can transfer in the cycle after N+1 at the earliest.
- There is exactly one idle cycle between packets. Throughput is 1 beat/cycle within a packet.
- Pass-through path (without the macro) is combinational: zero latency from slave to master inside `LOCKED`.
- `grant_valid` = 1 exactly while the state is `LOCKED`.
- Reset mid-packet: at the next edge the FSM is in `IDLE`, `m_tvalid` = 0 and `s_tready` = 0. The partial packet is truncated downstream, which is legal per the reset rule.
- Reset has priority over a TLAST handshake on the same edge.

## Configuration

`AXIS_ARB_OUT_REG_EN`
- **Defined:** a two-entry skid buffer is inserted on the master side.
  - All `m_*` outputs and `s_tready` are registered with no combinational path to `m_tready`.
  - Latency is +1 cycle; throughput stays 1 beat/cycle.
  - The FSM leaves `LOCKED` on the TLAST handshake into the skid buffer, not on the master port.
  - Skid buffer reset: empty, `m_tvalid` = 0.
- **Undefined:** combinational pass-through as described above.

## Structure

- Package `axi_stream_arb_pkg` holds:
  - the FSM state enum (`ARB_IDLE`, `ARB_LOCKED`);
  - an index-width function `idx_w(n)`;
  - a round-robin pick function (request vector, last grant → index).
- Sub-module `axi_stream_skid_buffer` is instantiated only under `AXIS_ARB_OUT_REG_EN`. It is parameterised by total payload width and is reusable elsewhere.

## Test plan

- **Single 3-beat packet:** NUM_SRC=4, packet on source 2 only, `m_tready`=1 → `grant_idx`=2 one cycle after the request; beats appear on consecutive cycles; `grant_valid` falls after the TLAST beat.
- **Round robin:** sources 0, 1 and 3 request continuously with 2-beat packets → grant order 0,1,3,0,1,3 with one idle cycle between packets.
- **Backpressure:** `m_tready` held 0 for 5 cycles mid-packet → `m_tdata/tlast` stable, `s_tready[grant]`=0, no beat lost or duplicated.
- **Late arrival:** source 0 requests while source 1 is `LOCKED` → source 1's packet completes uninterrupted, then source 0 is granted.
- **Reset mid-packet:** `areset` pulsed during beat 2 of 4 → next cycle `m_tvalid`=0 and `grant_valid`=0; after reset, source 0 has first priority.
- **Macro defined:** repeat scenarios 1 and 3 → identical beat sequence with +1 latency; run the AXI-Stream master property set on the master port.
